// File: rtl/dp_writeback_pkg.sv
// rtl/dp_writeback_pkg.sv - shared register/flag constants and pending-write entry layout
package dp_writeback_pkg;

    localparam logic [3:0] REG_SP = 4'd13;
    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int FLAG_W = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              we;
        logic              flag_we;
        logic [FLAG_W-1:0] flags;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/dp_writeback_if.sv
// rtl/dp_writeback_if.sv - execute-to-writeback result handshake
interface dp_writeback_if;
    import dp_writeback_pkg::*;

    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_rd_addr;
    logic [DATA_W-1:0] wb_rd_data;
    logic              wb_we;
    logic              wb_flag_we;
    logic              carry_in;
    logic              zero_in;
    logic              neg_in;

    modport master (
        output wb_valid, wb_rd_addr, wb_rd_data, wb_we, wb_flag_we,
               carry_in, zero_in, neg_in,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_rd_addr, wb_rd_data, wb_we, wb_flag_we,
               carry_in, zero_in, neg_in,
        output wb_ready
    );

endinterface

// File: rtl/dp_writeback_wb_queue.sv
// rtl/dp_writeback_wb_queue.sv - in-order pending-write circular buffer
module wb_queue
    import dp_writeback_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic [CNT_W-1:0]         count,
    output logic                     full,
    output logic                     empty,
    output logic [DEPTH*ENTRY_W-1:0] entries,
    output logic [DEPTH-1:0]         entry_valid
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only looked at while it is counted valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_entry;
    end

    // Entries are presented oldest-first so the bypass search can simply let the last match win.
    always_comb begin
        entries     = '0;
        entry_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            entries[k*ENTRY_W +: ENTRY_W] = mem[rd_ptr + PTR_W'(k)];
            entry_valid[k]                = (CNT_W'(k) < count);
        end
    end

endmodule

// File: rtl/dp_writeback.sv
// rtl/dp_writeback.sv - writeback stage: result queue, register file, APSR flags, operand bypass
module dp_writeback
    import dp_writeback_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] SP_RESET = 32'h0000_0000,
    localparam int         CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    dp_writeback_if.slave      wb,
    input  logic               wb_hold,
    input  logic [ADDR_W-1:0]  rn_addr,
    input  logic [ADDR_W-1:0]  rm_addr,
    input  logic [DATA_W-1:0]  pc_in,
    output logic [DATA_W-1:0]  rn_data,
    output logic [DATA_W-1:0]  rm_data,
    output logic               carry_q,
    output logic               zero_q,
    output logic               neg_q,
    output logic               flags_pending,
    output logic               branch_req,
    output logic [DATA_W-1:0]  branch_target
);

    logic [DATA_W-1:0]        regs [16];
    logic [FLAG_W-1:0]        flags;
    wb_entry_t                push_entry;
    wb_entry_t                head;
    wb_entry_t                byp_e;
    logic                     push;
    logic                     pop;
    logic [CNT_W-1:0]         q_count;
    logic                     q_full;
    logic                     q_empty;
    logic [DEPTH*ENTRY_W-1:0] q_entries;
    logic [DEPTH-1:0]         q_valid;

    assign wb.wb_ready = !q_full;
    assign push        = wb.wb_valid && wb.wb_ready;
    assign pop         = !q_empty && !wb_hold;

    always_comb begin
        push_entry                = '0;
        push_entry.addr           = wb.wb_rd_addr;
        push_entry.data           = wb.wb_rd_data;
        push_entry.we             = wb.wb_we;
        push_entry.flag_we        = wb.wb_flag_we;
        push_entry.flags[FLAG_N]  = wb.neg_in;
        push_entry.flags[FLAG_Z]  = wb.zero_in;
        push_entry.flags[FLAG_C]  = wb.carry_in;
    end

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head),
        .count       (q_count),
        .full        (q_full),
        .empty       (q_empty),
        .entries     (q_entries),
        .entry_valid (q_valid)
    );

    // r15 is never stored here; a committed PC write becomes a branch request instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            regs[REG_SP]  <= SP_RESET;
            flags         <= '0;
            branch_req    <= 1'b0;
            branch_target <= '0;
        end else begin
            branch_req <= 1'b0;
            if (pop) begin
                if (head.we && head.addr != REG_PC) regs[head.addr] <= head.data;
                if (head.flag_we) flags <= head.flags;
                if (head.we && head.addr == REG_PC) begin
                    branch_req    <= 1'b1;
                    branch_target <= {head.data[DATA_W-1:1], 1'b0};
                end
            end
        end
    end

    assign neg_q   = flags[FLAG_N];
    assign zero_q  = flags[FLAG_Z];
    assign carry_q = flags[FLAG_C];

    // Search runs oldest to youngest, so the youngest matching write overrides older ones.
    always_comb begin
        rn_data       = regs[rn_addr];
        rm_data       = regs[rm_addr];
        flags_pending = 1'b0;
        byp_e         = '0;
        if (q_count != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                byp_e = q_entries[k*ENTRY_W +: ENTRY_W];
                if (q_valid[k] && byp_e.we && byp_e.addr == rn_addr) rn_data = byp_e.data;
                if (q_valid[k] && byp_e.we && byp_e.addr == rm_addr) rm_data = byp_e.data;
                flags_pending = flags_pending | (q_valid[k] & byp_e.flag_we);
            end
        end
        if (rn_addr == REG_PC) rn_data = pc_in;
        if (rm_addr == REG_PC) rm_data = pc_in;
    end

endmodule

// File: tb/tb_dp_writeback.sv
// tb/tb_dp_writeback.sv - self-checking bench for dp_writeback
module tb_dp_writeback;
    import dp_writeback_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] SP_RST = 32'h2000_0400;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_hold;
    logic [3:0]  rn_addr, rm_addr;
    logic [31:0] pc_in, rn_data, rm_data, branch_target;
    logic        carry_q, zero_q, neg_q, flags_pending, branch_req;

    always #5 clk = ~clk;

    dp_writeback_if wbif ();

    dp_writeback #(.DEPTH(DEPTH), .SP_RESET(SP_RST)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb            (wbif),
        .wb_hold       (wb_hold),
        .rn_addr       (rn_addr),
        .rm_addr       (rm_addr),
        .pc_in         (pc_in),
        .rn_data       (rn_data),
        .rm_data       (rm_data),
        .carry_q       (carry_q),
        .zero_q        (zero_q),
        .neg_q         (neg_q),
        .flags_pending (flags_pending),
        .branch_req    (branch_req),
        .branch_target (branch_target)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic        we;
        logic        fwe;
        logic [2:0]  nzc;
    } ment_t;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic        we;
        logic        fwe;
        logic [2:0]  nzc;
        logic [31:0] exp_reg;
        logic [2:0]  exp_flags;
    } vec_t;

    ment_t       mq[$];
    logic [31:0] mregs [16];
    logic [2:0]  mflags;
    logic        mbr;
    logic [31:0] mtgt;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 16; i++) mregs[i] = 32'h0;
        mregs[13] = SP_RST;
        mflags = 3'b000;
        mbr = 1'b0;
        mtgt = 32'h0;
    endtask

    function automatic logic [31:0] mread(input logic [3:0] a);
        if (a == 4'd15) return pc_in;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].we && mq[i].addr == a) return mq[i].data;
        return mregs[a];
    endfunction

    function automatic logic mpending();
        foreach (mq[i]) if (mq[i].fwe) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic v, input logic [3:0] a, input logic [31:0] d,
                         input logic we, input logic fwe, input logic [2:0] nzc);
        wbif.wb_valid   = v;
        wbif.wb_rd_addr = a;
        wbif.wb_rd_data = d;
        wbif.wb_we      = we;
        wbif.wb_flag_we = fwe;
        wbif.neg_in     = nzc[2];
        wbif.zero_in    = nzc[1];
        wbif.carry_in   = nzc[0];
    endtask

    // One clock edge; the reference model applies the queue rules on the pre-edge inputs.
    task automatic cycle();
        logic  acc, com;
        ment_t e, h;
        acc = wbif.wb_valid && (mq.size() < DEPTH);
        com = (mq.size() > 0) && !wb_hold;
        e.addr = wbif.wb_rd_addr;
        e.data = wbif.wb_rd_data;
        e.we   = wbif.wb_we;
        e.fwe  = wbif.wb_flag_we;
        e.nzc  = {wbif.neg_in, wbif.zero_in, wbif.carry_in};
        @(posedge clk);
        mbr = 1'b0;
        if (com) begin
            h = mq.pop_front();
            if (h.we && h.addr == 4'd15) begin
                mbr  = 1'b1;
                mtgt = {h.data[31:1], 1'b0};
            end else if (h.we) begin
                mregs[h.addr] = h.data;
            end
            if (h.fwe) mflags = h.nzc;
        end
        if (acc) mq.push_back(e);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ready"},   wbif.wb_ready, (mq.size() < DEPTH));
        chk({tag, ".flags"},   {neg_q, zero_q, carry_q}, mflags);
        chk({tag, ".pending"}, flags_pending, mpending());
        chk({tag, ".br_req"},  branch_req, mbr);
        chk({tag, ".br_tgt"},  branch_target, mtgt);
        chk({tag, ".rn"},      rn_data, mread(rn_addr));
        chk({tag, ".rm"},      rm_data, mread(rm_addr));
    endtask

    task automatic check_reset_state(input string tag);
        logic [31:0] exp;
        pc_in = 32'h0000_0F00;
        for (int a = 0; a < 16; a++) begin
            rn_addr = 4'(a);
            rm_addr = 4'(15 - a);
            #1;
            exp = (a == 15) ? 32'h0000_0F00 : (a == 13) ? SP_RST : 32'h0;
            chk($sformatf("%s.rn_r%0d", tag, a), rn_data, exp);
            exp = (a == 0) ? 32'h0000_0F00 : (a == 2) ? SP_RST : 32'h0;
            chk($sformatf("%s.rm_r%0d", tag, 15 - a), rm_data, exp);
        end
        chk({tag, ".flags"},   {neg_q, zero_q, carry_q}, 3'b000);
        chk({tag, ".ready"},   wbif.wb_ready, 1'b1);
        chk({tag, ".br_req"},  branch_req, 1'b0);
        chk({tag, ".br_tgt"},  branch_target, 32'h0);
        chk({tag, ".pending"}, flags_pending, 1'b0);
    endtask

    vec_t        tbl [4];
    logic [2:0]  prev_flags;

    initial begin
        rst = 1'b1;
        wb_hold = 1'b0;
        rn_addr = 4'd0;
        rm_addr = 4'd0;
        pc_in = 32'h0;
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 3'b000);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("por");

        tbl[0] = '{4'd3,  32'h0000_00F0, 1'b1, 1'b1, 3'b001, 32'h0000_00F0, 3'b001};
        tbl[1] = '{4'd4,  32'h0000_0044, 1'b1, 1'b0, 3'b110, 32'h0000_0044, 3'b001};
        tbl[2] = '{4'd6,  32'h0000_0077, 1'b0, 1'b1, 3'b110, 32'h0000_0000, 3'b110};
        tbl[3] = '{4'd14, 32'hCAFE_0001, 1'b1, 1'b1, 3'b010, 32'hCAFE_0001, 3'b010};
        prev_flags = 3'b000;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, tbl[i].addr, tbl[i].data, tbl[i].we, tbl[i].fwe, tbl[i].nzc);
            cycle();
            drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 3'b000);
            rn_addr = tbl[i].addr;
            #1;
            chk($sformatf("vec%0d.flags_before", i), {neg_q, zero_q, carry_q}, prev_flags);
            chk($sformatf("vec%0d.pending", i), flags_pending, tbl[i].fwe);
            cycle();
            chk($sformatf("vec%0d.reg", i), rn_data, tbl[i].exp_reg);
            chk($sformatf("vec%0d.flags", i), {neg_q, zero_q, carry_q}, tbl[i].exp_flags);
            prev_flags = tbl[i].exp_flags;
        end

        // Backpressure: two held results fill the queue, a third is refused.
        wb_hold = 1'b1;
        drive(1'b1, 4'd1, 32'h11, 1'b1, 1'b1, 3'b100);
        cycle();
        chk("bp.ready1", wbif.wb_ready, 1'b1);
        chk("bp.pend1", flags_pending, 1'b1);
        drive(1'b1, 4'd2, 32'h22, 1'b1, 1'b0, 3'b000);
        cycle();
        chk("bp.ready2", wbif.wb_ready, 1'b0);
        chk("bp.pend2", flags_pending, 1'b1);
        drive(1'b1, 4'd7, 32'h99, 1'b1, 1'b1, 3'b011);
        cycle();
        chk("bp.ready3", wbif.wb_ready, 1'b0);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 3'b000);
        wb_hold = 1'b0;
        rn_addr = 4'd1;
        rm_addr = 4'd2;
        cycle();
        chk("bp.r1", rn_data, 32'h11);
        chk("bp.r2_byp", rm_data, 32'h22);
        chk("bp.flags", {neg_q, zero_q, carry_q}, 3'b100);
        chk("bp.pend3", flags_pending, 1'b0);
        chk("bp.ready4", wbif.wb_ready, 1'b1);
        cycle();
        rn_addr = 4'd7;
        #1;
        chk("bp.r2", rm_data, 32'h22);
        chk("bp.r7_unwritten", rn_data, 32'h0);
        chk("bp.flags2", {neg_q, zero_q, carry_q}, 3'b100);

        // Bypass ordering: youngest of two queued writes to r5 wins.
        wb_hold = 1'b1;
        drive(1'b1, 4'd5, 32'h0000_AAAA, 1'b1, 1'b0, 3'b000);
        cycle();
        drive(1'b1, 4'd5, 32'h0000_5555, 1'b1, 1'b0, 3'b000);
        cycle();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 3'b000);
        rn_addr = 4'd5;
        rm_addr = 4'd5;
        #1;
        chk("byp.rn_young", rn_data, 32'h0000_5555);
        chk("byp.rm_young", rm_data, 32'h0000_5555);
        wb_hold = 1'b0;
        cycle();
        chk("byp.mid_drain", rn_data, 32'h0000_5555);
        cycle();
        chk("byp.drained", rn_data, 32'h0000_5555);
        wb_hold = 1'b1;
        drive(1'b1, 4'd5, 32'h0000_1234, 1'b0, 1'b0, 3'b000);
        cycle();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 3'b000);
        chk("byp.we0_nobypass", rn_data, 32'h0000_5555);
        wb_hold = 1'b0;
        cycle();
        chk("byp.we0_commit", rn_data, 32'h0000_5555);

        // Branch on a committed r15 write.
        pc_in = 32'h0000_8000;
        drive(1'b1, 4'd15, 32'h0000_1235, 1'b1, 1'b0, 3'b000);
        cycle();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 3'b000);
        rn_addr = 4'd15;
        #1;
        chk("br.req_early", branch_req, 1'b0);
        chk("br.r15_pc", rn_data, 32'h0000_8000);
        cycle();
        rn_addr = 4'd14;
        #1;
        chk("br.req", branch_req, 1'b1);
        chk("br.tgt", branch_target, 32'h0000_1234);
        chk("br.r14_kept", rn_data, 32'hCAFE_0001);
        chk("br.r5_kept", rm_data, 32'h0000_5555);
        cycle();
        chk("br.req_drop", branch_req, 1'b0);
        chk("br.tgt_held", branch_target, 32'h0000_1234);

        // Back-to-back results: push and pop share every edge at count 1.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'(i), 32'(i * 3), 1'b1, 1'b0, 3'b000);
            cycle();
            chk($sformatf("pp.ready%0d", i), wbif.wb_ready, 1'b1);
        end
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 3'b000);
        cycle();
        for (int i = 0; i < 8; i++) begin
            rn_addr = 4'(i);
            #1;
            chk($sformatf("pp.r%0d", i), rn_data, 32'(i * 3));
        end

        // Reset mid-operation with a full, held queue.
        wb_hold = 1'b1;
        drive(1'b1, 4'd2, 32'h0000_BEEF, 1'b1, 1'b1, 3'b111);
        cycle();
        drive(1'b1, 4'd9, 32'h0000_0009, 1'b1, 1'b0, 3'b000);
        cycle();
        rst = 1'b1;
        model_reset();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 3'b000);
        wb_hold = 1'b0;
        check_reset_state("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        cycle();
        rn_addr = 4'd2;
        rm_addr = 4'd9;
        #1;
        chk("midrst.r2_discarded", rn_data, 32'h0);
        chk("midrst.r9_discarded", rm_data, 32'h0);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 9) < 7), 4'($urandom), $urandom,
                  ($urandom_range(0, 9) < 8), 1'($urandom), 3'($urandom));
            wb_hold = ($urandom_range(0, 9) < 3);
            pc_in   = $urandom;
            rn_addr = 4'($urandom);
            rm_addr = 4'($urandom);
            #1;
            check_model($sformatf("rnd%0d", n));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dp_writeback.md
Name: dp_writeback

Overview:
- Writeback stage directly downstream of the data-processing execute units (AND/ORR/ADD...). Accepts Rd result plus NZC flags via a valid/ready handshake and buffers them in a small in-order queue.
- Commits queued results into the 16x32 register file and the APSR N/Z/C flag register.
- Drives the Rn/Rm operand read ports that feed the execute stage, with bypass from still-queued writes. Raises a branch request when r15 (PC) is written.

Parameters:
- DEPTH, 2, pending-write queue entries (power of two, >=2).
- SP_RESET, 32'h0000_0000, reset value of r13 (SP).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- wb_valid  in  1  execute result valid.
- wb_ready  out  1  queue can accept; equals !full.
- wb_rd_addr  in  4  destination register.
- wb_rd_data  in  32  result (Rd).
- wb_we  in  1  write Rd (0 for TST/CMP-style ops).
- wb_flag_we  in  1  update flags (S bit).
- carry_in  in  1  C result from execute.
- zero_in  in  1  Z result from execute.
- neg_in  in  1  N result from execute.
- wb_hold  in  1  freeze commit (debug/stall); the queue still accepts while not full.
- rn_addr  in  4  operand A read address.
- rm_addr  in  4  operand B read address.
- pc_in  in  32  current PC value, returned for reads of r15.
- rn_data  out  32  operand A, combinational.
- rm_data  out  32  operand B, combinational.
- carry_q  out  1  committed C flag.
- zero_q  out  1  committed Z flag.
- neg_q  out  1  committed N flag.
- flags_pending  out  1  some queued entry has flag_we=1.
- branch_req  out  1  one-cycle pulse after a committed r15 write.
- branch_target  out  32  {data[31:1],1'b0} of that write; held until the next r15 commit.

Behaviour:
- Reset (async, immediate):
  - r0-r12 and r14 = 0; r13 = SP_RESET.
  - Flags = 0; queue empty (count=0, pointers=0).
  - wb_ready = 1; branch_req = 0; branch_target = 0; flags_pending = 0.
- Enqueue: at posedge when wb_valid && wb_ready, push {addr, data, we, flag_we, N, Z, C} at the tail.
  - wb_valid while !wb_ready is ignored. The producer must hold its inputs until accepted.
- Commit: at posedge when count>0 && !wb_hold, pop the head and apply it:
  - we=1 writes regs[addr] <= data.
  - flag_we=1 writes {N,Z,C} <= entry flags. Otherwise the flags are unchanged.
  - we=1 && addr==15: the regfile is not written; branch_req=1 for the following cycle and branch_target loads.
- Latency: a result accepted at edge N commits at edge N+1 at the earliest (empty queue, no hold). It is visible on carry_q/zero_q/neg_q after edge N+1.
- Simultaneous push and pop in one edge:
  - Count is unchanged; both pointers advance, wrapping modulo DEPTH.
  - Legal only when not full, because wb_ready comes from the pre-edge count.
- Full (count==DEPTH): wb_ready=0, even if a pop happens the same edge.
- Empty + wb_hold: no-op. A hold asserted mid-stream stops commits on the next edge; the queue is retained.
- Read ports, evaluated independently for rn and rm:
  - addr==15 returns pc_in.
  - Otherwise return data from the youngest queued entry with we=1 and a matching addr.
  - Otherwise return regs[addr].
  - The same-cycle wb_rd_data input is not bypassed.
- flags_pending = OR of flag_we over valid queue entries.
- Reset mid-operation discards all queued entries; no partial commit.

Decomposition:
- Shared package/defines header, which also holds shared constants with the execute units (existing Defines):
  - REG_SP=4'd13, REG_LR=4'd14, REG_PC=4'd15.
  - Flag bit positions N=2, Z=1, C=0.
  - Queue-entry field widths.
- Sub-module wb_queue: the parameterised circular buffer.
  - Outputs: head entry, count/full/empty.
  - Also exposes the flattened entries and their valid bits for the bypass search.
- The top level holds the register file, flags, the bypass mux and the branch logic.

Test Plan:
- Reset check: assert rst mid-run, then read all addresses. Expect r13=SP_RESET, the other GPRs 0, rn_data for r15 = pc_in, flags 000, wb_ready=1, branch_req=0.
- Basic commit: push r3=0x0000_00F0 with S=1, Z=0, N=0, C=1 and hold=0. One edge later regs[3]=0xF0 and carry_q=1. Push r4 with we=1, flag_we=0: the flags stay unchanged.
- Backpressure: wb_hold=1, push r1=0x11 then r2=0x22. Expect wb_ready=0 and flags_pending per input. A third push is ignored. Release hold: commits over two edges, r1 then r2, and the third value is never written.
- Bypass ordering: with hold=1, push r5=0xAAAA then r5=0x5555 (DEPTH=2). rn_addr=5 gives 0x5555 before any commit and regs[5]=0x5555 after the drain. A push with we=0 to r5 does not bypass.
- Branch: push r15=0x0000_1235 with we=1. Next edge: branch_req=1 for exactly one cycle and branch_target=0x0000_1234; the regfile is unchanged.
- Simultaneous push/pop at count=1: count stays 1 and the pointers wrap past DEPTH-1 without corruption. Checked over 8 consecutive results r0..r7=i*3.
